voice_allocator: RTL

Parametrised polyphonic voice allocator between the MIDI message decoder and the per-voice envelope/oscillator chains. It assigns incoming note-on events to free voices, with optional oldest-voice stealing when all voices are busy, and matches note-off events to held voices. It supports a sustain pedal and same-note retrigger. Per voice it drives note number, velocity, and one-cycle gate-on/gate-off pulses to the envelope generators.

---
 rtl/voice_pkg.sv | 18 +
 rtl/voice_slot.sv | 76 +++++++
 rtl/voice_allocator.sv | 126 ++++++++++++
 3 files changed

// File: rtl/voice_pkg.sv
// Shared types and default widths for the polyphonic voice allocator.
package voice_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD      = 2'd1,
        SUSTAINED = 2'd2
    } voice_state_t;

    localparam int DEF_NOTE_W = 7;
    localparam int DEF_VEL_W  = 7;
    localparam int DEF_ENV_W  = 7;

    function automatic int rank_w(input int voices);
        return (voices < 2) ? 1 : $clog2(voices);
    endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice: lifecycle state, note/velocity latch, age rank and gate pulse flops.
module voice_slot
    import voice_pkg::*;
#(
    parameter int              NOTE_W     = DEF_NOTE_W,
    parameter int              VEL_W      = DEF_VEL_W,
    parameter int              RANK_W     = 2,
    parameter logic [RANK_W-1:0] RESET_RANK = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              release_i,
    input  logic              sustain_i,
    input  logic              sus_release_i,
    input  logic              rank_clr_i,
    input  logic              rank_inc_i,
    input  logic [NOTE_W-1:0] note_i,
    input  logic [VEL_W-1:0]  vel_i,
    output voice_state_t      state_o,
    output logic [NOTE_W-1:0] note_o,
    output logic [VEL_W-1:0]  vel_o,
    output logic [RANK_W-1:0] rank_o,
    output logic              gate_on_o,
    output logic              gate_off_o
);

    voice_state_t      state_q, state_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [VEL_W-1:0]  vel_q, vel_d;
    logic [RANK_W-1:0] rank_q, rank_d;
    logic              gate_on_q, gate_off_q;

    // A load in the same cycle as a release wins, so the release pulse is swallowed.
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        vel_d   = vel_q;
        rank_d  = rank_q;
        if (release_i || sus_release_i) state_d = IDLE;
        if (sustain_i)                  state_d = SUSTAINED;
        if (load_i) begin
            state_d = HELD;
            note_d  = note_i;
            vel_d   = vel_i;
        end
        if (rank_clr_i)      rank_d = '0;
        else if (rank_inc_i) rank_d = rank_q + RANK_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            note_q     <= '0;
            vel_q      <= '0;
            rank_q     <= RESET_RANK;
            gate_on_q  <= 1'b0;
            gate_off_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            rank_q     <= rank_d;
            gate_on_q  <= load_i;
            gate_off_q <= (release_i | sus_release_i) & ~load_i;
        end
    end

    assign state_o    = state_q;
    assign note_o     = note_q;
    assign vel_o      = vel_q;
    assign rank_o     = rank_q;
    assign gate_on_o  = gate_on_q;
    assign gate_off_o = gate_off_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: retrigger / free / steal-oldest priority, note-off
// matching with sustain pedal, and age ranking of voices.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int VEL_W  = DEF_VEL_W,
    parameter int ENV_W  = DEF_ENV_W,
    parameter bit STEAL  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     note_on,
    input  logic                     note_off,
    input  logic                     sustain,
    input  logic [NOTE_W-1:0]        note_num,
    input  logic [VEL_W-1:0]         note_vel,
    input  logic [VOICES*ENV_W-1:0]  env_out,
    output logic [VOICES*NOTE_W-1:0] note_num_o,
    output logic [VOICES*VEL_W-1:0]  note_vel_o,
    output logic [VOICES-1:0]        gate_on,
    output logic [VOICES-1:0]        gate_off,
    output logic [VOICES-1:0]        held,
    output logic                     stolen,
    output logic                     dropped
);

    localparam int RANK_W = rank_w(VOICES);

    voice_state_t      state [VOICES];
    logic [NOTE_W-1:0] vnote [VOICES];
    logic [RANK_W-1:0] rank  [VOICES];

    logic [VOICES-1:0] off_match, off_sel, rel, sus_hold, sus_rel, post_idle;
    logic [VOICES-1:0] rt_match, free_v, oldest, load, rank_clr, rank_inc;
    logic [RANK_W-1:0] sel_rank;
    logic              sus_q, sus_fall, stolen_q, stolen_d, dropped_q, dropped_d;

    function automatic logic [VOICES-1:0] lowest(input logic [VOICES-1:0] v);
        return v & (~v + VOICES'(1));
    endfunction

    // Note-off and sustain release resolve first; note-on then sees the post-release states.
    always_comb begin
        sus_fall  = ce & sus_q & ~sustain;
        stolen_d  = 1'b0;
        dropped_d = 1'b0;
        load      = '0;
        sel_rank  = '0;
        for (int i = 0; i < VOICES; i++) begin
            off_match[i] = ce & note_off & (state[i] == HELD) & (vnote[i] == note_num);
            sus_rel[i]   = sus_fall & (state[i] == SUSTAINED);
        end
        off_sel  = lowest(off_match);
        rel      = sustain ? '0 : off_sel;
        sus_hold = sustain ? off_sel : '0;
        for (int i = 0; i < VOICES; i++) begin
            post_idle[i] = (state[i] == IDLE) | rel[i] | sus_rel[i];
            rt_match[i]  = ~post_idle[i] & (vnote[i] == note_num);
            free_v[i]    = post_idle[i] & (env_out[i*ENV_W +: ENV_W] == '0);
            oldest[i]    = (rank[i] == RANK_W'(VOICES-1));
        end
        if (ce && note_on) begin
            if (|rt_match)    load = lowest(rt_match);
            else if (|free_v) load = lowest(free_v);
            else if (STEAL) begin
                load     = oldest;
                stolen_d = 1'b1;
            end else begin
                dropped_d = 1'b1;
            end
        end
        for (int i = 0; i < VOICES; i++)
            if (load[i]) sel_rank = rank[i];
        for (int i = 0; i < VOICES; i++) begin
            rank_clr[i] = load[i];
            rank_inc[i] = (|load) & ~load[i] & (rank[i] < sel_rank);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sus_q     <= 1'b0;
            stolen_q  <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            if (ce) sus_q <= sustain;
            stolen_q  <= stolen_d;
            dropped_q <= dropped_d;
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        voice_slot #(
            .NOTE_W     (NOTE_W),
            .VEL_W      (VEL_W),
            .RANK_W     (RANK_W),
            .RESET_RANK (RANK_W'(VOICES-1-g))
        ) u_slot (
            .clk           (clk),
            .rst_n         (rst_n),
            .load_i        (load[g]),
            .release_i     (rel[g]),
            .sustain_i     (sus_hold[g]),
            .sus_release_i (sus_rel[g]),
            .rank_clr_i    (rank_clr[g]),
            .rank_inc_i    (rank_inc[g]),
            .note_i        (note_num),
            .vel_i         (note_vel),
            .state_o       (state[g]),
            .note_o        (vnote[g]),
            .vel_o         (note_vel_o[g*VEL_W +: VEL_W]),
            .rank_o        (rank[g]),
            .gate_on_o     (gate_on[g]),
            .gate_off_o    (gate_off[g])
        );
        assign note_num_o[g*NOTE_W +: NOTE_W] = vnote[g];
        assign held[g] = (state[g] != IDLE);
    end

    assign stolen  = stolen_q;
    assign dropped = dropped_q;

endmodule
